// File: rtl/regfile_fwd_pkg.sv
// Shared pipeline definitions for the ID-stage register file and forwarding unit.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
//
// Contents: index/data widths, register count, the hard-wired zero register,
// the RUN/HALTED state encoding and a destination-match helper.
package regfile_fwd_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // A destination of r0 never produces a usable value, so it never matches.
  function automatic logic dest_match(input logic [REG_IDX_W-1:0] dest,
                                      input logic [REG_IDX_W-1:0] idx);
    return (dest != ZERO_REG) && (dest == idx);
  endfunction

endpackage

// File: rtl/regfile_fwd_fwd_mux.sv
// Per-port operand select: EX, then MEM, then WB bypass, then the register array.
// Latency: combinational, zero cycles.
// Backpressure: none; the selection is purely combinational.
//
// Ports:
//   idx                         source register index of this port
//   ex_fwd/ex_desreg/ex_result  EX-stage bypass (ex_fwd excludes loads)
//   mem_regwrite/mem_desreg/mem_result  MEM-stage bypass
//   wb_regwrite/wb_desreg/wb_data       WB-stage write-first bypass
//   rf_data                     register array read value for idx
//   data                        selected operand
//   hit                         operand came from EX, MEM or WB
module fwd_mux
  import regfile_fwd_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 ex_fwd,
  input  logic [REG_IDX_W-1:0] ex_desreg,
  input  logic [DATA_W-1:0]    ex_result,
  input  logic                 mem_regwrite,
  input  logic [REG_IDX_W-1:0] mem_desreg,
  input  logic [DATA_W-1:0]    mem_result,
  input  logic                 wb_regwrite,
  input  logic [REG_IDX_W-1:0] wb_desreg,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic [DATA_W-1:0]    rf_data,
  output logic [DATA_W-1:0]    data,
  output logic                 hit
);

  always_comb begin
    data = rf_data;
    hit  = 1'b0;
    if (idx == ZERO_REG) begin
      data = '0;
    end else if (ex_fwd && dest_match(ex_desreg, idx)) begin
      data = ex_result;
      hit  = 1'b1;
    end else if (mem_regwrite && dest_match(mem_desreg, idx)) begin
      data = mem_result;
      hit  = 1'b1;
    end else if (wb_regwrite && dest_match(wb_desreg, idx)) begin
      data = wb_data;
      hit  = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_fwd.sv
// ID-stage 32x32 register file with EX/MEM/WB operand bypass, load-use detection and sticky halt.
// Latency: reads/forwarding combinational (0 cycles); writes and halt take effect at posedge clk.
// Backpressure: stall holds PC and IF/ID, flush_idex bubbles ID/EX on a load-use; HALTED holds stall high.
//
// Ports: clk, rst (sync, active-high); rs/rt + rs_used/rt_used from decode;
// ex_*, mem_*, wb_* stage destinations, enables and values; wb_halt;
// outputs rdata_a/rdata_b, stall, flush_idex, halted, stall_cnt, fwd_cnt.
// Optional macro FWD_STATS_EN enables the stall/forwarding counters;
// without it both counters are tied to zero.
module regfile_fwd
  import regfile_fwd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [REG_IDX_W-1:0] rt,
  input  logic                 rs_used,
  input  logic                 rt_used,
  input  logic [REG_IDX_W-1:0] ex_desreg,
  input  logic                 ex_regwrite,
  input  logic                 ex_memtoreg,
  input  logic [DATA_W-1:0]    ex_result,
  input  logic [REG_IDX_W-1:0] mem_desreg,
  input  logic                 mem_regwrite,
  input  logic [DATA_W-1:0]    mem_result,
  input  logic [REG_IDX_W-1:0] wb_desreg,
  input  logic                 wb_regwrite,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 wb_halt,
  output logic [DATA_W-1:0]    rdata_a,
  output logic [DATA_W-1:0]    rdata_b,
  output logic                 stall,
  output logic                 flush_idex,
  output logic                 halted,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          fwd_cnt
);

  state_t              state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                ex_fwd;
  logic                load_use;
  logic                hit_a;
  logic                hit_b;

  // A load in EX has no value yet, so it is excluded from EX forwarding and
  // instead triggers the load-use stall.
  assign ex_fwd = ex_regwrite && !ex_memtoreg;

  assign load_use = ex_regwrite && ex_memtoreg &&
                    ((rs_used && dest_match(ex_desreg, rs)) ||
                     (rt_used && dest_match(ex_desreg, rt)));

  assign stall      = (state == ST_HALTED) ? 1'b1 : load_use;
  assign flush_idex = (state == ST_RUN) && load_use;

  // Register array. r0 is never written, and the mux forces it to zero anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == ST_RUN && wb_regwrite && wb_desreg != ZERO_REG) begin
      regs[wb_desreg] <= wb_data;
    end
  end

  // Run/halt control. The write accompanying wb_halt still lands because the
  // array write above sees state==RUN on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (wb_halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          state  <= ST_HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  fwd_mux u_fwd_a (
    .idx          (rs),
    .ex_fwd       (ex_fwd),
    .ex_desreg    (ex_desreg),
    .ex_result    (ex_result),
    .mem_regwrite (mem_regwrite),
    .mem_desreg   (mem_desreg),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_desreg    (wb_desreg),
    .wb_data      (wb_data),
    .rf_data      (regs[rs]),
    .data         (rdata_a),
    .hit          (hit_a)
  );

  fwd_mux u_fwd_b (
    .idx          (rt),
    .ex_fwd       (ex_fwd),
    .ex_desreg    (ex_desreg),
    .ex_result    (ex_result),
    .mem_regwrite (mem_regwrite),
    .mem_desreg   (mem_desreg),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_desreg    (wb_desreg),
    .wb_data      (wb_data),
    .rf_data      (regs[rt]),
    .data         (rdata_b),
    .hit          (hit_b)
  );

`ifdef FWD_STATS_EN
  // Only operands the instruction actually reads count as forwarded.
  logic fwd_any;
  assign fwd_any = (rs_used && hit_a) || (rt_used && hit_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (state == ST_RUN) begin
      if (load_use) stall_cnt <= stall_cnt + 32'd1;
      if (fwd_any)  fwd_cnt   <= fwd_cnt + 32'd1;
    end
  end
`else
  logic unused_hits;
  assign unused_hits = hit_a ^ hit_b;
  assign stall_cnt   = '0;
  assign fwd_cnt     = '0;
`endif

endmodule

// File: tb/tb_regfile_fwd.sv
// Self-checking bench for regfile_fwd: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file rules.
module tb_regfile_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, ex_desreg, mem_desreg, wb_desreg;
  logic        rs_used, rt_used, ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite, wb_halt;
  logic [31:0] ex_result, mem_result, wb_data;
  logic [31:0] rdata_a, rdata_b, stall_cnt, fwd_cnt;
  logic        stall, flush_idex, halted;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_halted;
  logic [31:0] m_stall_cnt, m_fwd_cnt;

  always #5 clk = ~clk;

  regfile_fwd dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
    .ex_desreg(ex_desreg), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_result(ex_result), .mem_desreg(mem_desreg), .mem_regwrite(mem_regwrite),
    .mem_result(mem_result), .wb_desreg(wb_desreg), .wb_regwrite(wb_regwrite),
    .wb_data(wb_data), .wb_halt(wb_halt), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .stall(stall), .flush_idex(flush_idex), .halted(halted),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (ex_regwrite && !ex_memtoreg && ex_desreg == idx) return ex_result;
    if (mem_regwrite && mem_desreg == idx) return mem_result;
    if (wb_regwrite && wb_desreg == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit m_hit(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
    return (ex_regwrite && !ex_memtoreg && ex_desreg == idx) ||
           (mem_regwrite && mem_desreg == idx) ||
           (wb_regwrite && wb_desreg == idx);
  endfunction

  function automatic bit m_hazard();
    return ex_regwrite && ex_memtoreg && ex_desreg != 0 &&
           ((rs_used && ex_desreg == rs) || (rt_used && ex_desreg == rt));
  endfunction

  // Advance model by one edge with the current inputs, then step the clock.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_halted = 1'b0;
      m_stall_cnt = 32'd0;
      m_fwd_cnt = 32'd0;
    end else if (!m_halted) begin
`ifdef FWD_STATS_EN
      if (m_hazard()) m_stall_cnt = m_stall_cnt + 32'd1;
      if ((rs_used && m_hit(rs)) || (rt_used && m_hit(rt))) m_fwd_cnt = m_fwd_cnt + 32'd1;
`endif
      if (wb_regwrite && wb_desreg != 0) m_regs[wb_desreg] = wb_data;
      if (wb_halt) m_halted = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 0; rs = 0; rt = 0; rs_used = 0; rt_used = 0;
    ex_desreg = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_result = 0;
    mem_desreg = 0; mem_regwrite = 0; mem_result = 0;
    wb_desreg = 0; wb_regwrite = 0; wb_data = 0; wb_halt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    rs = 5'd9; rt = 5'd17; rs_used = 1; rt_used = 1;
    #1;
    checks++; if (rdata_a !== 32'd0) begin errors++; $display("FAIL reset_rdata_a got %h want 0", rdata_a); end
    checks++; if (rdata_b !== 32'd0) begin errors++; $display("FAIL reset_rdata_b got %h want 0", rdata_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (flush_idex !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush_idex); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    checks++; if (fwd_cnt !== 32'd0) begin errors++; $display("FAIL reset_fwd_cnt got %0d want 0", fwd_cnt); end
  endtask

  task automatic test_write_first();
    clear_inputs();
    wb_regwrite = 1; wb_desreg = 5'd5; wb_data = 32'h1234; rs = 5'd5; rs_used = 1;
    #1;
    checks++; if (rdata_a !== 32'h1234) begin errors++; $display("FAIL wfirst_bypass got %h want 1234", rdata_a); end
    tick();
    clear_inputs();
    rs = 5'd5; rs_used = 1;
    #1;
    checks++; if (rdata_a !== 32'h1234) begin errors++; $display("FAIL wfirst_array got %h want 1234", rdata_a); end
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    ex_regwrite = 1; ex_desreg = 3; ex_result = 32'hAAAA;
    mem_regwrite = 1; mem_desreg = 3; mem_result = 32'hBBBB;
    wb_regwrite = 1; wb_desreg = 3; wb_data = 32'hCCCC;
    rt = 3; rt_used = 1;
    #1;
    checks++; if (rdata_b !== 32'hAAAA) begin errors++; $display("FAIL prio_ex got %h want aaaa", rdata_b); end
    ex_regwrite = 0;
    #1;
    checks++; if (rdata_b !== 32'hBBBB) begin errors++; $display("FAIL prio_mem got %h want bbbb", rdata_b); end
    mem_regwrite = 0;
    #1;
    checks++; if (rdata_b !== 32'hCCCC) begin errors++; $display("FAIL prio_wb got %h want cccc", rdata_b); end
    // A load in EX is not a forwarding source; MEM wins instead.
    ex_regwrite = 1; ex_memtoreg = 1; mem_regwrite = 1;
    #1;
    checks++; if (rdata_b !== 32'hBBBB) begin errors++; $display("FAIL prio_load_skip got %h want bbbb", rdata_b); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_regwrite = 1; ex_memtoreg = 1; ex_desreg = 7; rs = 7; rs_used = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
    checks++; if (flush_idex !== 1'b1) begin errors++; $display("FAIL lu_flush got %b want 1", flush_idex); end
    tick();
    clear_inputs();
    mem_regwrite = 1; mem_desreg = 7; mem_result = 32'h55; rs = 7; rs_used = 1;
    #1;
    checks++; if (rdata_a !== 32'h55) begin errors++; $display("FAIL lu_mem_fwd got %h want 55", rdata_a); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %b want 0", stall); end
    tick();
    // Matching index but operand not used: no hazard.
    clear_inputs();
    ex_regwrite = 1; ex_memtoreg = 1; ex_desreg = 7; rt = 7; rt_used = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_unused got %b want 0", stall); end
    rt_used = 1;
    #1;
    checks++; if (flush_idex !== 1'b1) begin errors++; $display("FAIL lu_rt_flush got %b want 1", flush_idex); end
    tick();
  endtask

  task automatic test_zero_reg();
    logic [31:0] fwd_before;
    clear_inputs();
    tick();
    fwd_before = fwd_cnt;
    wb_regwrite = 1; wb_desreg = 0; wb_data = 32'hFFFF;
    ex_regwrite = 1; ex_desreg = 0; ex_result = 32'h1;
    rs = 0; rt = 0; rs_used = 1; rt_used = 1;
    #1;
    checks++; if (rdata_a !== 32'd0) begin errors++; $display("FAIL zero_rdata_a got %h want 0", rdata_a); end
    checks++; if (rdata_b !== 32'd0) begin errors++; $display("FAIL zero_rdata_b got %h want 0", rdata_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %b want 0", stall); end
    tick();
    checks++; if (fwd_cnt !== fwd_before) begin errors++; $display("FAIL zero_fwd_cnt got %0d want %0d", fwd_cnt, fwd_before); end
    clear_inputs();
    ex_regwrite = 1; ex_memtoreg = 1; ex_desreg = 0; rs_used = 1; rt_used = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_load_stall got %b want 0", stall); end
    checks++; if (rdata_a !== 32'd0) begin errors++; $display("FAIL zero_array got %h want 0", rdata_a); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
      rs_used = 1'($urandom); rt_used = 1'($urandom);
      ex_desreg = 5'($urandom_range(0, 7)); ex_regwrite = 1'($urandom);
      ex_memtoreg = ($urandom_range(0, 3) == 0); ex_result = $urandom;
      mem_desreg = 5'($urandom_range(0, 7)); mem_regwrite = 1'($urandom); mem_result = $urandom;
      wb_desreg = 5'($urandom_range(0, 7)); wb_regwrite = 1'($urandom); wb_data = $urandom;
      #1;
      checks++; if (rdata_a !== m_read(rs)) begin errors++; $display("FAIL rnd_rdata_a it=%0d got %h want %h", n, rdata_a, m_read(rs)); end
      checks++; if (rdata_b !== m_read(rt)) begin errors++; $display("FAIL rnd_rdata_b it=%0d got %h want %h", n, rdata_b, m_read(rt)); end
      checks++; if (stall !== m_hazard()) begin errors++; $display("FAIL rnd_stall it=%0d got %b want %b", n, stall, m_hazard()); end
      checks++; if (flush_idex !== m_hazard()) begin errors++; $display("FAIL rnd_flush it=%0d got %b want %b", n, flush_idex, m_hazard()); end
      tick();
      checks++; if (stall_cnt !== m_stall_cnt) begin errors++; $display("FAIL rnd_stall_cnt it=%0d got %0d want %0d", n, stall_cnt, m_stall_cnt); end
      checks++; if (fwd_cnt !== m_fwd_cnt) begin errors++; $display("FAIL rnd_fwd_cnt it=%0d got %0d want %0d", n, fwd_cnt, m_fwd_cnt); end
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_stall, exp_fwd;
    do_reset();
`ifdef FWD_STATS_EN
    exp_stall = 32'd3; exp_fwd = 32'd4;
`else
    exp_stall = 32'd0; exp_fwd = 32'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      ex_regwrite = 1; ex_memtoreg = 1; ex_desreg = 5'(i + 4); rs = 5'(i + 4); rs_used = 1;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      ex_regwrite = 1; ex_desreg = 3; ex_result = 32'(i); rt = 3; rt_used = 1; rs = 3; rs_used = 1;
      tick();
    end
    clear_inputs();
    tick();
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL stats_stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
    checks++; if (fwd_cnt !== exp_fwd) begin errors++; $display("FAIL stats_fwd_cnt got %0d want %0d", fwd_cnt, exp_fwd); end
    do_reset();
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_rst_stall got %0d want 0", stall_cnt); end
    checks++; if (fwd_cnt !== 32'd0) begin errors++; $display("FAIL stats_rst_fwd got %0d want 0", fwd_cnt); end
  endtask

  task automatic test_halt();
    logic [31:0] sc, fc;
    do_reset();
    wb_regwrite = 1; wb_desreg = 2; wb_data = 32'h9; wb_halt = 1;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_pre got %b want 0", halted); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL halt_pre_stall got %b want 0", stall); end
    tick();
    clear_inputs();
    rs = 2; rs_used = 1;
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %b want 1", halted); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL halt_stall got %b want 1", stall); end
    checks++; if (rdata_a !== 32'h9) begin errors++; $display("FAIL halt_last_write got %h want 9", rdata_a); end
    sc = stall_cnt; fc = fwd_cnt;
    wb_regwrite = 1; wb_desreg = 2; wb_data = 32'h7;
    ex_regwrite = 1; ex_memtoreg = 1; ex_desreg = 2;
    #1;
    checks++; if (flush_idex !== 1'b0) begin errors++; $display("FAIL halt_no_flush got %b want 0", flush_idex); end
    tick();
    clear_inputs();
    rs = 2; rs_used = 1;
    #1;
    checks++; if (rdata_a !== 32'h9) begin errors++; $display("FAIL halt_write_blocked got %h want 9", rdata_a); end
    checks++; if (stall_cnt !== sc) begin errors++; $display("FAIL halt_stall_frozen got %0d want %0d", stall_cnt, sc); end
    checks++; if (fwd_cnt !== fc) begin errors++; $display("FAIL halt_fwd_frozen got %0d want %0d", fwd_cnt, fc); end
    // Reset wins even while a hazard is present.
    ex_regwrite = 1; ex_memtoreg = 1; ex_desreg = 2; rst = 1;
    tick();
    clear_inputs();
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst got %b want 0", halted); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL halt_rst_stall got %b want 0", stall); end
    for (int r = 0; r < 32; r++) begin
      rs = 5'(r); rt = 5'(31 - r);
      #1;
      checks++; if (rdata_a !== 32'd0) begin errors++; $display("FAIL halt_rst_reg r%0d got %h want 0", r, rdata_a); end
    end
    // Hazard coincident with wb_halt: stall follows hazard, HALTED from the next edge.
    clear_inputs();
    ex_regwrite = 1; ex_memtoreg = 1; ex_desreg = 6; rt = 6; rt_used = 1; wb_halt = 1;
    #1;
    checks++; if (flush_idex !== 1'b1) begin errors++; $display("FAIL halt_hz_flush got %b want 1", flush_idex); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL halt_hz_stall got %b want 1", stall); end
    tick();
    wb_halt = 0;
    #1;
    checks++; if (flush_idex !== 1'b0) begin errors++; $display("FAIL halt_hz_next_flush got %b want 0", flush_idex); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hz_next_halted got %b want 1", halted); end
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_halted = 0; m_stall_cnt = 0; m_fwd_cnt = 0;
    @(negedge clk);
    test_reset();
    test_write_first();
    test_priority();
    test_load_use();
    test_zero_reg();
    test_random();
    test_stats();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
